perfect_number_generator: RTL and testbench
===========================================

Name: perfect_number_generator

Overview:
- Source-side companion to the perfect-number checker. Scans an inclusive candidate range [lo, hi] and computes each candidate's proper-divisor sum by repeated-subtraction remainders.
- Emits every perfect number found, in ascending order, on a valid/ready output handshake.
- Feeds the checker or a display/logging stage. Control style matches the checker: go starts a run, over flags completion.

Parameters:
- WIDTH, 16, candidate/bound/output width in bits.
- CNT_W, 8, width of the found-counter.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset, asynchronous, active-low (asserted when 0).
- go  input  1  start request; level-sampled in IDLE only.
- lo  input  WIDTH  lower bound, latched at start.
- hi  input  WIDTH  upper bound, latched at start.
- out_num  output  WIDTH  perfect number being offered.
- out_valid  output  1  out_num valid.
- out_ready  input  1  consumer accepts when out_valid && out_ready at a clk edge.
- busy  output  1  high from start until over rises.
- over  output  1  scan complete; held until go is low.
- found  output  CNT_W  perfect numbers accepted this run; saturates at all-ones.

Behaviour:
- Reset (rst=0, async): state=IDLE; out_num=0, out_valid=0, busy=0, over=0, found=0; internal n/d/rem/sum=0.
- Reset is honoured mid-operation, including in EMIT. An offered value is dropped and not re-offered after reset.
- One datapath operation per cycle. Registers: n (WIDTH), d (WIDTH), rem (WIDTH), sum (WIDTH+1).
- IDLE: when go=1, latch lo/hi, set n=max(lo,2), clear found, set busy=1, go to INIT.
  - If latched lo>hi, or hi<2, go straight to DONE with no emission.
- INIT: sum=1, d=2 -> CHK_D.
- CHK_D:
  - d>=n: -> DECIDE.
  - otherwise: rem=n -> SUB.
- SUB: each cycle, if rem>=d then rem=rem-d and stay in SUB, else -> ACC.
- ACC: if rem==0 then sum=sum+d. Early exit: if the new sum > n -> NEXT_N (abundant). Otherwise d=d+1 -> CHK_D.
- DECIDE:
  - sum==n: drive out_num=n, out_valid=1 -> EMIT.
  - otherwise: -> NEXT_N.
- EMIT: hold out_num and out_valid=1 stable until out_ready=1 at an edge. On that edge: out_valid=0, found++ (saturating) -> NEXT_N. No timeout.
- NEXT_N:
  - n==hi: -> DONE. Compare before incrementing, so hi=all-ones never wraps to 0.
  - otherwise: n=n+1 -> INIT.
- DONE: busy=0, over=1. Return to IDLE (over=0) only when go=0. go held high keeps over asserted and starts no new run.
- sum is WIDTH+1 bits. Early exit bounds it below 2n, so it never overflows. n=1 is never evaluated.
- go and lo/hi changes during a run are ignored.
- Only one value is outstanding at a time. out_valid never rises in the same cycle it falls.
- Latency from go to over with no perfects in range is data-dependent. The bench must use range-bounded timeouts, not fixed cycle counts.

Decomposition:
- Package perfect_pkg holds:
  - state enum: IDLE, INIT, CHK_D, SUB, ACC, DECIDE, EMIT, NEXT_N, DONE.
  - default WIDTH and CNT_W constants.
  - MIN_CANDIDATE=2.
- One natural sub-module, mod_subtract: holds rem. Inputs are load, step, value, divisor; outputs are rem, ge (rem>=divisor), zero. The FSM sequences it.
- The FSM and the n/d/sum registers live in perfect_number_generator.

Test Plan:
- lo=0, hi=30, out_ready=1, go=1: out_valid pulses with out_num=6 then 28, nothing else; over=1, found=2, busy=0.
- lo=28, hi=28, out_ready=0 for 40 cycles after out_valid rises, then 1: out_num=28 and out_valid=1 stable all 40 cycles; one acceptance; found=1; over.
- lo=30, hi=20, go=1: over=1 within 3 cycles, out_valid never asserts, found=0. Hold go=1 for 20 cycles: over stays 1. Drop go: IDLE, over=0.
- lo=0xFFFC, hi=0xFFFF: no emission. over asserts, n never observed wrapping to 0, found=0.
- lo=8120, hi=8130: single emission, out_num=8128 (0x1FC0), found=1.
- Drive rst=0 while in EMIT for 496 (lo=490, hi=500, out_ready=0): all outputs 0 immediately, asynchronously. After release with go=0, remains IDLE with no spurious out_valid.

Source files
------------

// File: rtl/perfect_pkg.sv
// perfect_pkg: shared state encoding and defaults for the perfect-number generator.
package perfect_pkg;
    typedef enum logic [3:0] {
        IDLE,
        INIT,
        CHK_D,
        SUB,
        ACC,
        DECIDE,
        EMIT,
        NEXT_N,
        DONE
    } state_t;
    localparam int DEF_WIDTH = 16;
    localparam int DEF_CNT_W = 8;
    localparam int MIN_CANDIDATE = 2;
endpackage

// File: rtl/mod_subtract.sv
// mod_subtract: remainder register reduced by one subtraction of divisor per step.
module mod_subtract #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] value,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem,
    output logic             ge,
    output logic             zero
);
    assign ge   = rem >= divisor;
    assign zero = rem == '0;
    always_ff @(posedge clk or negedge rst)
        if (!rst)
            rem <= '0;
        else if (load)
            rem <= value;
        else if (step && ge)
            rem <= rem - divisor;
endmodule

// File: rtl/perfect_number_generator.sv
// perfect_number_generator: scans [lo, hi] and emits each perfect number on a valid/ready port.
module perfect_number_generator
    import perfect_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] out_num,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             over,
    output logic [CNT_W-1:0] found
);
    localparam logic [WIDTH-1:0] MIN_N = WIDTH'(MIN_CANDIDATE);
    state_t           state, nxt;
    logic [WIDTH-1:0] n, d, hi_q, rem;
    logic [WIDTH:0]   sum, sum_acc;
    logic             ge, zero;
    mod_subtract #(.WIDTH(WIDTH)) u_sub (
        .clk    (clk),
        .rst    (rst),
        .load   (state == CHK_D && d < n),
        .step   (state == SUB),
        .value  (n),
        .divisor(d),
        .rem    (rem),
        .ge     (ge),
        .zero   (zero)
    );
    assign sum_acc   = sum + (zero ? {1'b0, d} : '0);
    assign out_valid = state == EMIT;
    assign over      = state == DONE;
    assign busy      = state != IDLE && state != DONE;
    always_ff @(posedge clk or negedge rst)
        if (!rst)
            state <= IDLE;
        else
            state <= nxt;
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (go) nxt = (lo > hi || hi < MIN_N) ? DONE : INIT;
            INIT:    nxt = CHK_D;
            CHK_D:   nxt = (d >= n) ? DECIDE : SUB;
            SUB:     nxt = ge ? SUB : ACC;
            ACC:     nxt = (sum_acc > {1'b0, n}) ? NEXT_N : CHK_D;
            DECIDE:  nxt = (sum == {1'b0, n}) ? EMIT : NEXT_N;
            EMIT:    nxt = out_ready ? NEXT_N : EMIT;
            NEXT_N:  nxt = (n == hi_q) ? DONE : INIT;
            DONE:    nxt = go ? DONE : IDLE;
            default: nxt = IDLE;
        endcase
    end
    // n stops at hi_q before incrementing, so an all-ones bound cannot wrap
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            n       <= '0;
            d       <= '0;
            sum     <= '0;
            hi_q    <= '0;
            out_num <= '0;
            found   <= '0;
        end else begin
            case (state)
                IDLE:
                    if (go) begin
                        n     <= (lo > MIN_N) ? lo : MIN_N;
                        hi_q  <= hi;
                        found <= '0;
                    end
                INIT: begin
                    sum <= (WIDTH+1)'(1);
                    d   <= MIN_N;
                end
                ACC: begin
                    sum <= sum_acc;
                    d   <= d + 1'b1;
                end
                DECIDE:  out_num <= n;
                EMIT:    if (out_ready && found != '1) found <= found + 1'b1;
                NEXT_N:  if (n != hi_q) n <= n + 1'b1;
                default: ;
            endcase
        end
endmodule

// File: tb/tb_perfect_number_generator.sv
// tb_perfect_number_generator: randomized scoreboard bench against a divisor-sum reference model.
module tb_perfect_number_generator;
    localparam int W = 9;
    localparam int C = 8;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         go = 1'b0;
    logic         out_ready;
    logic         out_valid, busy, over;
    logic [W-1:0] lo = '0;
    logic [W-1:0] hi = '0;
    logic [W-1:0] out_num;
    logic [C-1:0] found;
    int           checks = 0;
    int           failures = 0;
    int           hold = 0;
    int           q[$];

    perfect_number_generator #(.WIDTH(W), .CNT_W(C)) dut (
        .clk      (clk),
        .rst      (rst),
        .go       (go),
        .lo       (lo),
        .hi       (hi),
        .out_num  (out_num),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy),
        .over     (over),
        .found    (found)
    );

    always #5 clk = ~clk;

    function automatic bit perf(input int n);
        int s = 0;
        for (int k = 1; k < n; k++) if (n % k == 0) s += k;
        return n > 1 && s == n;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // consumer: ready only after an offer has been visible for 'hold' cycles
    initial begin
        int vcnt = 0;
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            vcnt = out_valid ? vcnt + 1 : 0;
            out_ready = out_valid ? (vcnt >= hold) : (hold == 0);
        end
    end

    // monitor: pops the scoreboard on each acceptance and checks offers stay stable
    initial begin
        logic         pv = 1'b0;
        logic         pacc = 1'b0;
        logic [W-1:0] pn = '0;
        forever begin
            @(negedge clk);
            if (!rst) pv = 1'b0;
            else begin
                if (pv && !pacc) begin
                    chk("hold_valid", int'(out_valid), 1);
                    chk("hold_num", int'(out_num), int'(pn));
                end
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_out: got %0d expected none", out_num);
                    end else chk("out_num", int'(out_num), q.pop_front());
                end
                pv   = out_valid;
                pacc = out_valid && out_ready;
                pn   = out_num;
            end
        end
    end

    task automatic run(input int l, input int h, input int hc, input int linger);
        int exp_found = 0;
        int budget = 50 + 50 * hc;
        int i;
        hold = hc;
        if (l <= h && h >= 2)
            for (int n = (l > 2 ? l : 2); n <= h; n++) begin
                budget += 12 * n + 10;
                if (perf(n)) begin
                    q.push_back(n);
                    exp_found++;
                end
            end
        lo = W'(l);
        hi = W'(h);
        go = 1'b1;
        for (i = 0; i < budget && !over; i++) begin
            @(posedge clk);
            #1;
        end
        chk("over", int'(over), 1);
        if (l > h) chk("quick_over", int'(i <= 3), 1);
        chk("found", int'(found), exp_found);
        chk("busy", int'(busy), 0);
        chk("pending", q.size(), 0);
        if (linger > 0) begin
            repeat (linger) begin
                @(posedge clk);
                #1;
            end
            chk("over_held", int'(over), 1);
            chk("found_held", int'(found), exp_found);
        end
        go = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_over", int'(over), 0);
        q.delete();
    endtask

    initial begin
        int bad;
        int i;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_num", int'(out_num), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_over", int'(over), 0);
        chk("rst_found", int'(found), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        run(0, 30, 0, 0);
        run(28, 28, 40, 0);
        run(30, 20, 0, 20);
        run(510, 511, 0, 0);
        run(6, 6, 2, 0);
        repeat (4) run($urandom_range(0, 40), $urandom_range(0, 40), $urandom_range(0, 3), 0);
        hold = 100000;
        q.push_back(496);
        lo = W'(494);
        hi = W'(500);
        go = 1'b1;
        for (i = 0; i < 20000 && !out_valid; i++) begin
            @(posedge clk);
            #1;
        end
        chk("emit_valid", int'(out_valid), 1);
        chk("emit_num", int'(out_num), 496);
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("async_valid", int'(out_valid), 0);
        chk("async_num", int'(out_num), 0);
        chk("async_busy", int'(busy), 0);
        chk("async_over", int'(over), 0);
        chk("async_found", int'(found), 0);
        q.delete();
        go = 1'b0;
        #20;
        @(posedge clk);
        #1;
        rst = 1'b1;
        bad = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            bad += int'(out_valid | busy | over);
        end
        chk("post_rst_idle", bad, 0);
        run(0, 10, 1, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
